// File: rtl/bus_arbiter_nx1_pkg.sv
// rtl/bus_arbiter_nx1_pkg.sv - shared state encodings and bus constants for the N-to-1 arbiter
package bus_arbiter_nx1_pkg;

  localparam int BE_W = 4;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY   = 2'd1,
    ARB_LOCKED = 2'd2
  } arb_state_t;

endpackage

// File: rtl/bus_arbiter_nx1_rr_pick.sv
// rtl/bus_arbiter_nx1_rr_pick.sv - combinational round-robin picker (first requester at or after ptr)
module rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  localparam logic [IDX_W:0] N_W = (IDX_W + 1)'(N);

  logic [2*N-1:0] req2;
  logic [N-1:0]   rot;
  logic [IDX_W:0] sum;

  // Rotate a doubled request vector so bit 0 is the pointer position, then take the lowest set bit
  always_comb begin
    req2 = {req, req};
    rot  = N'(req2 >> ptr);
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    sum  = '0;
    for (int i = 0; i < N; i++) begin
      if (!any && rot[i]) begin
        any = 1'b1;
        sum = {1'b0, ptr} + (IDX_W + 1)'(i);
        if (sum >= N_W) begin
          sum = sum - N_W;
        end
        idx = sum[IDX_W-1:0];
      end
    end
    if (any) begin
      gnt[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/bus_arbiter_nx1.sv
// rtl/bus_arbiter_nx1.sv - N-master round-robin shared-bus arbiter; optional grant lock via ARB_LOCK_EN
module bus_arbiter_nx1
  import bus_arbiter_nx1_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int XLEN      = 32
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [N_MASTERS-1:0]      i_bus_en,
  input  logic [N_MASTERS-1:0]      i_wr_en,
  input  logic [N_MASTERS*XLEN-1:0] i_wr_data,
  input  logic [N_MASTERS*XLEN-1:0] i_addr,
  input  logic [N_MASTERS*BE_W-1:0] i_byte_en,
`ifdef ARB_LOCK_EN
  input  logic [N_MASTERS-1:0]      i_lock,
`endif
  output logic [N_MASTERS-1:0]      o_ack,
  output logic [XLEN-1:0]           o_rd_data,
  input  logic                      i_ack,
  input  logic [XLEN-1:0]           i_rd_data,
  output logic                      o_bus_en,
  output logic                      o_wr_en,
  output logic [XLEN-1:0]           o_wr_data,
  output logic [XLEN-1:0]           o_addr,
  output logic [BE_W-1:0]           o_byte_en,
  output logic [N_MASTERS-1:0]      o_grant
);

  localparam int IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  arb_state_t             state_q, state_d;
  logic [N_MASTERS-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [N_MASTERS-1:0]   pick_gnt;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_any;
  logic                   g_req;

  rr_pick #(
    .N     (N_MASTERS),
    .IDX_W (IDX_W)
  ) u_pick (
    .req (i_bus_en),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign o_grant   = grant_q;
  assign o_rd_data = i_rd_data;
  assign g_req     = |(i_bus_en & grant_q);

  // State, grant and round-robin pointer registers
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next-state logic and the one-hot grant mux onto the slave side
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    o_bus_en  = 1'b0;
    o_wr_en   = 1'b0;
    o_wr_data = '0;
    o_addr    = '0;
    o_byte_en = '0;
    o_ack     = '0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          state_d = ARB_BUSY;
          grant_d = pick_gnt;
          ptr_d   = (pick_idx == IDX_W'(N_MASTERS - 1)) ? '0 : pick_idx + 1'b1;
        end
      end
      ARB_BUSY: begin
        for (int m = 0; m < N_MASTERS; m++) begin
          if (grant_q[m]) begin
            o_wr_en   = i_wr_en[m];
            o_wr_data = i_wr_data[m*XLEN +: XLEN];
            o_addr    = i_addr[m*XLEN +: XLEN];
            o_byte_en = i_byte_en[m*BE_W +: BE_W];
          end
        end
        o_bus_en = g_req;
        o_ack    = grant_q & {N_MASTERS{i_ack}};
        if (i_ack) begin
`ifdef ARB_LOCK_EN
          if (|(i_lock & grant_q)) begin
            state_d = ARB_LOCKED;
          end else begin
            state_d = ARB_IDLE;
            grant_d = '0;
          end
`else
          state_d = ARB_IDLE;
          grant_d = '0;
`endif
        end else if (!g_req) begin
          state_d = ARB_IDLE;
          grant_d = '0;
        end
      end
`ifdef ARB_LOCK_EN
      ARB_LOCKED: begin
        if (g_req) begin
          state_d = ARB_BUSY;
        end else if (!(|(i_lock & grant_q))) begin
          state_d = ARB_IDLE;
          grant_d = '0;
        end
      end
`endif
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter_nx1.sv
// tb/tb_bus_arbiter_nx1.sv - scoreboard bench for bus_arbiter_nx1 with N=4
module tb_bus_arbiter_nx1;

  localparam int N    = 4;
  localparam int XLEN = 32;

  typedef struct {
    int          m;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
  } txn_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [N-1:0]      m_en;
  logic [N-1:0]      m_wr;
  logic [31:0]       m_addr [N];
  logic [31:0]       m_data [N];
  logic [3:0]        m_be   [N];
  int                m_left [N];
`ifdef ARB_LOCK_EN
  logic [N-1:0]      m_lock;
`endif

  logic [N-1:0]      bus_en, wr_en;
  logic [N*XLEN-1:0] wr_data, addr;
  logic [N*4-1:0]    byte_en;
  logic              ack;
  logic [XLEN-1:0]   rd_data;
  logic              rd_force;
  logic              stray;
  int                ack_dly;
  int                scnt;
  logic [N-1:0]      ack_seen;

  logic [N-1:0]      o_ack;
  logic [XLEN-1:0]   o_rd_data;
  logic              o_bus_en;
  logic              o_wr_en;
  logic [XLEN-1:0]   o_wr_data;
  logic [XLEN-1:0]   o_addr;
  logic [3:0]        o_byte_en;
  logic [N-1:0]      o_grant;

  txn_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always_comb begin
    bus_en  = m_en;
    wr_en   = m_wr;
    wr_data = '0;
    addr    = '0;
    byte_en = '0;
    for (int m = 0; m < N; m++) begin
      wr_data[m*XLEN +: XLEN] = m_data[m];
      addr[m*XLEN +: XLEN]    = m_addr[m];
      byte_en[m*4 +: 4]       = m_be[m];
    end
  end

  always_comb rd_data = rd_force ? 32'hDEAD_BEEF : ~o_addr;

  bus_arbiter_nx1 #(
    .N_MASTERS (N),
    .XLEN      (XLEN)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_bus_en  (bus_en),
    .i_wr_en   (wr_en),
    .i_wr_data (wr_data),
    .i_addr    (addr),
    .i_byte_en (byte_en),
`ifdef ARB_LOCK_EN
    .i_lock    (m_lock),
`endif
    .o_ack     (o_ack),
    .o_rd_data (o_rd_data),
    .i_ack     (ack),
    .i_rd_data (rd_data),
    .o_bus_en  (o_bus_en),
    .o_wr_en   (o_wr_en),
    .o_wr_data (o_wr_data),
    .o_addr    (o_addr),
    .o_byte_en (o_byte_en),
    .o_grant   (o_grant)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic push_exp(input int m, input logic [31:0] a, input logic wr,
                          input logic [31:0] d, input logic [3:0] be);
    txn_t t;
    t.m     = m;
    t.addr  = a;
    t.wr    = wr;
    t.wdata = d;
    t.be    = be;
    t.rdata = rd_force ? 32'hDEAD_BEEF : ~a;
    exp_q.push_back(t);
  endtask

  task automatic set_master(input int m, input logic wr, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] be, input int left);
    m_wr[m]   = wr;
    m_addr[m] = a;
    m_data[m] = d;
    m_be[m]   = be;
    m_left[m] = left;
  endtask

  task automatic cycle();
    txn_t e;
    @(posedge clk);
    #1;
    for (int m = 0; m < N; m++) begin
      if (ack_seen[m]) begin
        if (m_left[m] > 0) begin
          m_left[m] = m_left[m] - 1;
          m_addr[m] = m_addr[m] + 32'd4;
          m_data[m] = m_data[m] + 32'd1;
        end else begin
          m_en[m] = 1'b0;
`ifdef ARB_LOCK_EN
          m_lock[m] = 1'b0;
`endif
        end
      end
    end
    ack_seen = '0;
    ack      = stray;
    @(negedge clk);
    if (o_bus_en) begin
      if (scnt == ack_dly) begin
        ack  = 1'b1;
        scnt = 0;
      end else begin
        scnt++;
      end
    end else begin
      scnt = 0;
    end
    #1;
    if (o_ack != '0) begin
      ack_seen = o_ack;
      if (exp_q.size() == 0) begin
        check("stray_ack", o_ack, 0);
      end else begin
        e = exp_q.pop_front();
        check("sb_ack", o_ack, 64'(1) << e.m);
        check("sb_addr", o_addr, e.addr);
        check("sb_wr_en", o_wr_en, e.wr);
        check("sb_be", o_byte_en, e.be);
        check("sb_rdata", o_rd_data, e.rdata);
        if (e.wr) check("sb_wdata", o_wr_data, e.wdata);
      end
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while ((exp_q.size() != 0 || m_en != '0) && n < 200) begin
      cycle();
      n++;
    end
    if (n >= 200) check("timeout", n, 0);
    cycle();
  endtask

  task automatic reset_cycle();
    rst = 1'b0;
    cycle();
    rst = 1'b1;
  endtask

  logic [N-1:0] want_g;

  initial begin
    rst      = 1'b0;
    m_en     = '0;
    m_wr     = '0;
    ack      = 1'b0;
    rd_force = 1'b0;
    stray    = 1'b0;
    ack_dly  = 1;
    scnt     = 0;
    ack_seen = '0;
`ifdef ARB_LOCK_EN
    m_lock   = '0;
`endif
    for (int m = 0; m < N; m++) set_master(m, 1'b0, 32'h0, 32'h0, 4'hF, 0);

    // reset held with every master requesting
    m_en = '1;
    for (int c = 0; c < 3; c++) begin
      cycle();
      check("rst_bus_en", o_bus_en, 0);
      check("rst_grant", o_grant, 0);
      check("rst_ack", o_ack, 0);
    end
    m_en = '0;
    rst  = 1'b1;
    cycle();

    // single read from master 2
    ack_dly  = 2;
    rd_force = 1'b1;
    set_master(2, 1'b0, 32'h100, 32'h0, 4'hF, 0);
    push_exp(2, 32'h100, 1'b0, 32'h0, 4'hF);
    m_en[2] = 1'b1;
    cycle();
    check("rd_bus_en", o_bus_en, 1);
    check("rd_addr", o_addr, 32'h100);
    check("rd_grant", o_grant, 4'b0100);
    wait_done();
    rd_force = 1'b0;

    // fairness with all four requesting continuously
    reset_cycle();
    ack_dly = 1;
    for (int m = 0; m < N; m++) set_master(m, 1'b0, 32'h1000 + 32'(m) * 32'h100, 32'h0, 4'hF, (m == 0) ? 1 : 0);
    for (int m = 0; m < N; m++) push_exp(m, 32'h1000 + 32'(m) * 32'h100, 1'b0, 32'h0, 4'hF);
    push_exp(0, 32'h1004, 1'b0, 32'h0, 4'hF);
    m_en = '1;
    for (int c = 0; c < 15; c++) begin
      cycle();
      want_g = ((c % 3) == 2) ? 4'b0000 : 4'(1 << ((c / 3) % 4));
      check("rr_grant", o_grant, want_g);
    end
    check("rr_sb_empty", exp_q.size(), 0);
    wait_done();

    // write forwarding from master 1
    ack_dly = 1;
    set_master(1, 1'b1, 32'h2004, 32'hA5A5_A5A5, 4'b0011, 0);
    push_exp(1, 32'h2004, 1'b1, 32'hA5A5_A5A5, 4'b0011);
    m_en[1] = 1'b1;
    cycle();
    check("wr_en", o_wr_en, 1);
    check("wr_be", o_byte_en, 4'b0011);
    check("wr_data", o_wr_data, 32'hA5A5_A5A5);
    check("wr_addr", o_addr, 32'h2004);
    check("wr_grant", o_grant, 4'b0010);
    wait_done();

    // abort by the granted master, then a stray ack while idle
    ack_dly = 5;
    set_master(3, 1'b0, 32'h3000, 32'h0, 4'hF, 0);
    m_en[3] = 1'b1;
    cycle();
    check("abort_grant0", o_grant, 4'b1000);
    m_en[3] = 1'b0;
    cycle();
    check("abort_grant", o_grant, 0);
    check("abort_bus_en", o_bus_en, 0);
    check("abort_ack", o_ack, 0);
    stray = 1'b1;
    cycle();
    check("stray_idle_ack", o_ack, 0);
    check("stray_idle_grant", o_grant, 0);
    stray = 1'b0;
    cycle();

    // reset in the middle of a transaction, then a late ack
    set_master(0, 1'b0, 32'h3100, 32'h0, 4'hF, 0);
    m_en[0] = 1'b1;
    cycle();
    check("rstmid_grant0", o_grant, 4'b0001);
    rst = 1'b0;
    cycle();
    check("rstmid_grant", o_grant, 0);
    check("rstmid_bus_en", o_bus_en, 0);
    rst     = 1'b1;
    m_en[0] = 1'b0;
    stray   = 1'b1;
    cycle();
    check("rstmid_late_ack", o_ack, 0);
    stray = 1'b0;
    cycle();

`ifdef ARB_LOCK_EN
    // master 0 locks across two transactions while master 1 waits
    reset_cycle();
    ack_dly = 1;
    set_master(0, 1'b0, 32'h4000, 32'h0, 4'hF, 1);
    set_master(1, 1'b0, 32'h5000, 32'h0, 4'hF, 0);
    push_exp(0, 32'h4000, 1'b0, 32'h0, 4'hF);
    push_exp(0, 32'h4004, 1'b0, 32'h0, 4'hF);
    push_exp(1, 32'h5000, 1'b0, 32'h0, 4'hF);
    m_lock[0] = 1'b1;
    m_en      = 4'b0011;
    for (int c = 0; c < 10; c++) begin
      cycle();
      want_g = (c < 6) ? 4'b0001 : ((c == 7 || c == 8) ? 4'b0010 : 4'b0000);
      check("lock_grant", o_grant, want_g);
    end
    wait_done();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
